la_operand_bridge: RTL and testbench

LA_OPERAND_BRIDGE -- requirements
Module: la_operand_bridge

---
 rtl/la_operand_bridge.sv | 262 ++++++++++++++++++++++++++
 tb/tb_la_operand_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_operand_bridge.sv
// ---------------------------------------------------------------------------
// la_operand_bridge
//
// Purpose:
//   Bridges a toggle-strobed logic-analyzer command port to a GF(2^m)
//   arithmetic core. Operand words are written in over the narrow LA bus and
//   assembled into NUM_OPS slots of OP_W bits. START hands the operands to
//   the core with a valid/ready handshake. The core's OP_W-bit result is then
//   read back one LA word at a time, least significant word first.
//
// Ports:
//   wb_clk_i     single clock; all state changes on its rising edge
//   wb_rst_n     asynchronous active-low reset
//   la_data_in   write data word
//   la_cmd_i     command: 00 WRITE, 01 READ, 10 START, 11 CLEAR
//   la_strobe_i  toggle line; each level change issues one command
//   la_data_out  read data word
//   la_ack_o     toggles once per executed command
//   la_status_o  {error, done, busy, rd_avail}
//   op_data_o    packed operands, slot 0 in the LSBs
//   op_valid_o   operands valid toward the core
//   op_ready_i   core accepts the operands
//   res_data_i   result from the core
//   res_valid_i  result valid from the core
//   res_ready_o  bridge ready to take a result
//
// Optional feature:
//   LA_BRIDGE_TIMEOUT_EN  when defined, gives up waiting for a result after
//                         TIMEOUT cycles, flags error and returns to IDLE.
// ---------------------------------------------------------------------------
module la_operand_bridge #(
  parameter int LA_W    = 32,
  parameter int OP_W    = 163,
  parameter int NUM_OPS = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic [LA_W-1:0]         la_data_in,
  input  logic [1:0]              la_cmd_i,
  input  logic                    la_strobe_i,
  output logic [LA_W-1:0]         la_data_out,
  output logic                    la_ack_o,
  output logic [3:0]              la_status_o,
  output logic [NUM_OPS*OP_W-1:0] op_data_o,
  output logic                    op_valid_o,
  input  logic                    op_ready_i,
  input  logic [OP_W-1:0]         res_data_i,
  input  logic                    res_valid_i,
  output logic                    res_ready_o
);

  localparam int WPO    = (OP_W + LA_W - 1) / LA_W;
  localparam int TOTAL  = NUM_OPS * WPO;
  localparam int SLOT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int WCNT_W = (WPO > 1) ? $clog2(WPO) : 1;
  localparam int CNT_W  = $clog2(TOTAL + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_OPS - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WPO - 1);
  localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TOTAL);

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_START = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  if (TIMEOUT < 1) begin : g_paramCheck
    $error("la_operand_bridge: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    READOUT  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_strobeQ;
  logic               r_ack;
  logic               r_error;
  logic               r_done;
  logic               r_opValid;
  logic               r_resReady;
  logic [LA_W-1:0]    r_dataOut;
  logic [SLOT_W-1:0]  r_slot;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]   r_wrCount;
  logic [WCNT_W-1:0]  r_rdPtr;
  logic [OP_W-1:0]    r_result;

`ifdef LA_BRIDGE_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0]   r_timer;
`endif

  logic                        w_cmdEvt;
  logic                        w_wrEn;
  logic                        w_clrEn;
  logic [WPO-1:0][LA_W-1:0]    w_resWords;

  // A command is any level change of the strobe since the last edge.
  assign w_cmdEvt = (la_strobe_i != r_strobeQ);
  assign w_wrEn   = w_cmdEvt && (la_cmd_i == CMD_WRITE) && (r_state == IDLE);
  assign w_clrEn  = w_cmdEvt && (la_cmd_i == CMD_CLEAR);

  // Result zero-extended to a whole number of LA words for readout.
  assign w_resWords = (WPO * LA_W)'(r_result);

  // Operand storage: one register per slot/word, sized so that bits at or
  // above OP_W of the final word of each slot are never stored.
  for (genvar s = 0; s < NUM_OPS; s++) begin : g_slot
    for (genvar w = 0; w < WPO; w++) begin : g_word
      localparam int BITS = ((OP_W - w * LA_W) < LA_W) ? (OP_W - w * LA_W) : LA_W;
      localparam logic [SLOT_W-1:0] S_ID = SLOT_W'(s);
      localparam logic [WCNT_W-1:0] W_ID = WCNT_W'(w);
      logic [BITS-1:0] r_word;

      always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
          r_word <= '0;
        end else if (w_clrEn) begin
          r_word <= '0;
        end else if (w_wrEn && (r_slot == S_ID) && (r_wcnt == W_ID)) begin
          r_word <= la_data_in[BITS-1:0];
        end
      end

      assign op_data_o[s*OP_W + w*LA_W +: BITS] = r_word;
    end
  end

  // Main control FSM. Core handshakes advance first; a command in the same
  // cycle is applied afterwards so that CLEAR overrides any handshake.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= IDLE;
      r_strobeQ  <= 1'b0;
      r_ack      <= 1'b0;
      r_error    <= 1'b0;
      r_done     <= 1'b0;
      r_opValid  <= 1'b0;
      r_resReady <= 1'b0;
      r_dataOut  <= '0;
      r_slot     <= '0;
      r_wcnt     <= '0;
      r_wrCount  <= '0;
      r_rdPtr    <= '0;
      r_result   <= '0;
`ifdef LA_BRIDGE_TIMEOUT_EN
      r_timer    <= '0;
`endif
    end else begin
      r_strobeQ <= la_strobe_i;
      if (w_cmdEvt) begin
        r_ack <= ~r_ack;
      end

      case (r_state)
        ISSUE: begin
          if (op_ready_i) begin
            r_state    <= WAIT_RES;
            r_opValid  <= 1'b0;
            r_resReady <= 1'b1;
`ifdef LA_BRIDGE_TIMEOUT_EN
            r_timer    <= '0;
`endif
          end
        end
        WAIT_RES: begin
          if (res_valid_i) begin
            r_result   <= res_data_i;
            r_state    <= READOUT;
            r_resReady <= 1'b0;
            r_rdPtr    <= '0;
          end
`ifdef LA_BRIDGE_TIMEOUT_EN
          else if (r_timer == TMR_LAST) begin
            r_error    <= 1'b1;
            r_state    <= IDLE;
            r_resReady <= 1'b0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
`endif
        end
        default: ;
      endcase

      if (w_cmdEvt) begin
        case (la_cmd_i)
          CMD_WRITE: begin
            if (r_state == IDLE) begin
              if (r_wcnt == WCNT_LAST) begin
                r_wcnt <= '0;
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
              end else begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
              end
              if (r_wrCount != TOTAL_C) begin
                r_wrCount <= r_wrCount + CNT_W'(1);
              end
            end else begin
              r_error <= 1'b1;
            end
          end
          CMD_START: begin
            if ((r_state == IDLE) && (r_wrCount == TOTAL_C)) begin
              r_state   <= ISSUE;
              r_opValid <= 1'b1;
              r_wrCount <= '0;
              r_done    <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
          CMD_READ: begin
            if (r_state == READOUT) begin
              r_dataOut <= w_resWords[r_rdPtr];
              if (r_rdPtr == WCNT_LAST) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end else begin
                r_rdPtr <= r_rdPtr + WCNT_W'(1);
              end
            end else begin
              r_error   <= 1'b1;
              r_dataOut <= '0;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
            r_opValid  <= 1'b0;
            r_resReady <= 1'b0;
            r_dataOut  <= '0;
            r_slot     <= '0;
            r_wcnt     <= '0;
            r_wrCount  <= '0;
            r_rdPtr    <= '0;
            r_result   <= '0;
`ifdef LA_BRIDGE_TIMEOUT_EN
            r_timer    <= '0;
`endif
          end
        endcase
      end
    end
  end

  assign la_data_out = r_dataOut;
  assign la_ack_o    = r_ack;
  assign op_valid_o  = r_opValid;
  assign res_ready_o = r_resReady;
  assign la_status_o = {r_error, r_done,
                        (r_state == ISSUE) || (r_state == WAIT_RES),
                        (r_state == READOUT)};

endmodule

// File: tb/tb_la_operand_bridge.sv
// ---------------------------------------------------------------------------
// tb_la_operand_bridge
//
// Directed, table-driven bench for la_operand_bridge at default widths
// (LA_W=32, OP_W=163, NUM_OPS=4, so 6 words per operand and 24 words total).
// TIMEOUT is set to 16 so the optional watchdog is quick when enabled.
// ---------------------------------------------------------------------------
module tb_la_operand_bridge;

  localparam int LA_W    = 32;
  localparam int OP_W    = 163;
  localparam int NUM_OPS = 4;
  localparam int TIMEOUT = 16;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_START = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  logic                    clk;
  logic                    rstN;
  logic [LA_W-1:0]         laDataIn;
  logic [1:0]              laCmd;
  logic                    laStrobe;
  logic [LA_W-1:0]         laDataOut;
  logic                    laAck;
  logic [3:0]              laStatus;
  logic [NUM_OPS*OP_W-1:0] opData;
  logic                    opValid;
  logic                    opReady;
  logic [OP_W-1:0]         resData;
  logic                    resValid;
  logic                    resReady;

  la_operand_bridge #(
    .LA_W    (LA_W),
    .OP_W    (OP_W),
    .NUM_OPS (NUM_OPS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rstN),
    .la_data_in  (laDataIn),
    .la_cmd_i    (laCmd),
    .la_strobe_i (laStrobe),
    .la_data_out (laDataOut),
    .la_ack_o    (laAck),
    .la_status_o (laStatus),
    .op_data_o   (opData),
    .op_valid_o  (opValid),
    .op_ready_i  (opReady),
    .res_data_i  (resData),
    .res_valid_i (resValid),
    .res_ready_o (resReady)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] data;
    logic [31:0] expData;
    logic [3:0]  expStatus;
  } vec_t;

  vec_t vecs [64];
  int   nVec;
  int   nChecks;
  int   nFails;
  logic expAck;

  // Compares one observed value with the bench's expectation
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one command by toggling the strobe, then samples just after the edge
  task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] data);
    @(negedge clk);
    laCmd    = cmd;
    laDataIn = data;
    laStrobe = ~laStrobe;
    expAck   = ~expAck;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [1:0] cmd, input logic [31:0] data,
                        input logic [31:0] expData, input logic [3:0] expStatus);
    vecs[nVec].cmd       = cmd;
    vecs[nVec].data      = data;
    vecs[nVec].expData   = expData;
    vecs[nVec].expStatus = expStatus;
    nVec++;
  endtask

  task automatic runTable(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].data);
      checkOutput($sformatf("vec%0d_status", i), 64'(laStatus), 64'(vecs[i].expStatus));
      checkOutput($sformatf("vec%0d_data", i), 64'(laDataOut), 64'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_ack", i), 64'(laAck), 64'(expAck));
    end
  endtask

  // 24 writes of base+1..base+24 followed by START
  task automatic loadAndStart(input logic [31:0] base);
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(CMD_WRITE, base + 32'(i));
    end
    applyStimulus(CMD_START, 32'h0);
  endtask

  // One-cycle op_ready pulse; the bridge moves from ISSUE to WAIT_RES
  task automatic handshakeIssue(input string tag);
    @(negedge clk);
    opReady = 1'b1;
    @(posedge clk);
    #1;
    opReady = 1'b0;
    checkOutput({tag, "_opvalid_low"}, 64'(opValid), 64'd0);
    checkOutput({tag, "_resready_high"}, 64'(resReady), 64'd1);
    checkOutput({tag, "_status_wait"}, 64'(laStatus), 64'b0010);
  endtask

  // Global watchdog so the run can never hang
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    nChecks  = 0;
    nFails   = 0;
    nVec     = 0;
    expAck   = 1'b0;
    rstN     = 1'b0;
    laDataIn = '0;
    laCmd    = CMD_WRITE;
    laStrobe = 1'b0;
    opReady  = 1'b0;
    resData  = '0;
    resValid = 1'b0;

    // Error path: one word short, START refused, READ in IDLE refused
    for (int i = 1; i <= 23; i++) addVec(CMD_WRITE, 32'(i), 32'h0, 4'b0000);
    addVec(CMD_START, 32'h0, 32'h0, 4'b1000);
    addVec(CMD_CLEAR, 32'h0, 32'h0, 4'b0000);
    addVec(CMD_READ,  32'h0, 32'h0, 4'b1000);
    addVec(CMD_CLEAR, 32'h0, 32'h0, 4'b0000);
    // Good load: 24 words then START enters ISSUE (busy)
    for (int i = 1; i <= 24; i++) addVec(CMD_WRITE, 32'(i), 32'h0, 4'b0000);
    addVec(CMD_START, 32'h0, 32'h0, 4'b0010);
    // Readout of the result, LSW first, then one read too many
    addVec(CMD_READ, 32'h0, 32'hDEADBEEF, 4'b0001);
    addVec(CMD_READ, 32'h0, 32'h0,        4'b0001);
    addVec(CMD_READ, 32'h0, 32'h0,        4'b0001);
    addVec(CMD_READ, 32'h0, 32'h0,        4'b0001);
    addVec(CMD_READ, 32'h0, 32'h0,        4'b0001);
    addVec(CMD_READ, 32'h0, 32'h5,        4'b0100);
    addVec(CMD_READ, 32'h0, 32'h0,        4'b1100);
    addVec(CMD_CLEAR, 32'h0, 32'h0,       4'b0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_status",  64'(laStatus),  64'd0);
    checkOutput("rst_ack",     64'(laAck),     64'd0);
    checkOutput("rst_dataout", 64'(laDataOut), 64'd0);
    checkOutput("rst_opvalid", 64'(opValid),   64'd0);
    checkOutput("rst_resready",64'(resReady),  64'd0);
    checkOutput("rst_opdata",  64'(|opData),   64'd0);
    @(negedge clk);
    rstN = 1'b1;

    runTable(0, 26);
    checkOutput("short_opvalid", 64'(opValid), 64'd0);

    runTable(27, 51);
    checkOutput("issue_opvalid",   64'(opValid), 64'd1);
    checkOutput("slot0_word0",     64'(opData[31:0]), 64'h1);
    checkOutput("slot0_word1",     64'(opData[63:32]), 64'h2);
    checkOutput("slot0_top3",      64'(opData[162:160]), 64'h6);
    checkOutput("slot1_word0",     64'(opData[163 +: 32]), 64'h7);
    checkOutput("slot2_word0",     64'(opData[326 +: 32]), 64'hD);
    checkOutput("slot3_top3",      64'(opData[651:649]), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("issue_hold_opvalid", 64'(opValid), 64'd1);
    checkOutput("issue_hold_slot0",   64'(opData[31:0]), 64'h1);
    handshakeIssue("flow");

    @(negedge clk);
    resData  = {3'h5, 128'h0, 32'hDEADBEEF};
    resValid = 1'b1;
    @(posedge clk);
    #1;
    resValid = 1'b0;
    checkOutput("capture_status",   64'(laStatus), 64'b0001);
    checkOutput("capture_resready", 64'(resReady), 64'd0);
    runTable(52, 59);

    // CLEAR in the same cycle as res_valid: CLEAR wins, result discarded
    loadAndStart(32'h40);
    handshakeIssue("clr");
    @(negedge clk);
    resData  = {3'h7, 128'h0, 32'h12345678};
    resValid = 1'b1;
    laCmd    = CMD_CLEAR;
    laStrobe = ~laStrobe;
    expAck   = ~expAck;
    @(posedge clk);
    #1;
    resValid = 1'b0;
    checkOutput("clrres_status",   64'(laStatus), 64'd0);
    checkOutput("clrres_resready", 64'(resReady), 64'd0);
    checkOutput("clrres_ack",      64'(laAck), 64'(expAck));
    checkOutput("clrres_opdata",   64'(|opData), 64'd0);
    applyStimulus(CMD_READ, 32'h0);
    checkOutput("clrres_read_data",   64'(laDataOut), 64'd0);
    checkOutput("clrres_read_status", 64'(laStatus), 64'b1000);

    // WRITE and START while busy are ignored but flag error and still ack
    applyStimulus(CMD_CLEAR, 32'h0);
    loadAndStart(32'h100);
    applyStimulus(CMD_WRITE, 32'hFFFFFFFF);
    checkOutput("busywr_status",  64'(laStatus), 64'b1010);
    checkOutput("busywr_ack",     64'(laAck), 64'(expAck));
    checkOutput("busywr_slot0",   64'(opData[31:0]), 64'h101);
    applyStimulus(CMD_START, 32'h0);
    checkOutput("busystart_status",  64'(laStatus), 64'b1010);
    checkOutput("busystart_opvalid", 64'(opValid), 64'd1);
    applyStimulus(CMD_CLEAR, 32'h0);
    checkOutput("busyclr_status",  64'(laStatus), 64'd0);
    checkOutput("busyclr_opvalid", 64'(opValid), 64'd0);

    // Waiting for a result that never arrives
    loadAndStart(32'h0);
    handshakeIssue("wait");
`ifdef LA_BRIDGE_TIMEOUT_EN
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checkOutput("tmo_before_status",   64'(laStatus), 64'b0010);
    checkOutput("tmo_before_resready", 64'(resReady), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("tmo_status",   64'(laStatus), 64'b1000);
    checkOutput("tmo_resready", 64'(resReady), 64'd0);
`else
    repeat (2000) @(posedge clk);
    #1;
    checkOutput("nowdog_status",   64'(laStatus), 64'b0010);
    checkOutput("nowdog_resready", 64'(resReady), 64'd1);
`endif
    applyStimulus(CMD_CLEAR, 32'h0);
    checkOutput("wait_clr_status",   64'(laStatus), 64'd0);
    checkOutput("wait_clr_resready", 64'(resReady), 64'd0);

    // Asynchronous reset while in ISSUE
    loadAndStart(32'h20);
    checkOutput("prerst_opvalid", 64'(opValid), 64'd1);
    @(negedge clk);
    #1;
    rstN     = 1'b0;
    laStrobe = 1'b0;
    expAck   = 1'b0;
    #1;
    checkOutput("arst_opvalid",  64'(opValid),   64'd0);
    checkOutput("arst_status",   64'(laStatus),  64'd0);
    checkOutput("arst_ack",      64'(laAck),     64'd0);
    checkOutput("arst_dataout",  64'(laDataOut), 64'd0);
    checkOutput("arst_resready", 64'(resReady),  64'd0);
    checkOutput("arst_opdata",   64'(|opData),   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst_ack",    64'(laAck), 64'd0);
    checkOutput("postrst_status", 64'(laStatus), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
